jtoutrun_adc: RTL and testbench
===============================

Name: jtoutrun_adc

Overview:
- Emulates the cabinet ADC (ADC0804-style) that the OutRun main CPU reads for steering, accelerator and brake.
- Sits between the game top's cabinet inputs (joyana_*, joystick1, ctrl_type) and the main CPU I/O decode.
- CPU writes a channel number to start a conversion, waits, then reads an 8-bit result.
- With digital controls, synthesises analog-like ramps from joystick/buttons once per frame.

Parameters:
CONV_TICKS, 64, cen ticks from conversion start until result valid
RAMP_STEP, 8, per-frame step of the synthesised ramps (unsigned 8-bit)
STEER_MIN, 8'h20, lowest steering code
STEER_MAX, 8'hE0, highest steering code

Ports:
clk  in  1  system clock (clk48 domain)
rst_n  in  1  asynchronous active-low reset
cen  in  1  CPU clock enable; timebase for conversion
vs  in  1  vertical sync; rising edge = frame tick
ctrl_type  in  3  0 = digital joystick, otherwise analog
joystick1  in  8  active-low; [0] right, [1] left, [4] gas, [5] brake
joyana1  in  16  [7:0] signed steering
joyana1b  in  16  [7:0] gas and [15:8] brake, both unsigned
ch_we  in  1  CPU write strobe: latch channel, start conversion
ch_din  in  3  channel select
rd  in  1  CPU read strobe
dout  out  8  last completed conversion
busy  out  1  conversion in progress (INTR inverse)

Behaviour:
- Reset (async, rst_n=0):
  - dout=0, busy=0, channel=0, tick counter=0.
  - steer ramp=8'h80, gas ramp=0, brake ramp=0, vs edge register=0.
- Source values (combinational):
  - ch0 steering:
    - Analog: joyana1[7:0]^8'h80, clamped to [STEER_MIN, STEER_MAX].
    - Digital: steer ramp.
  - ch1 gas: analog joyana1b[7:0]; digital gas ramp.
  - ch2 brake: analog joyana1b[15:8]; digital brake ramp.
  - ch3..7: 8'h00.
- Digital ramps: update only on a vs rising edge (registered edge detect, 1-cycle latency).
  - Steering, left held: move down by RAMP_STEP, saturate at STEER_MIN.
  - Steering, right held: move up by RAMP_STEP, saturate at STEER_MAX.
  - Steering, both or neither held: move toward 8'h80 by RAMP_STEP, never overshooting.
  - Gas/brake, button pressed: move up toward 8'hFF by RAMP_STEP, saturate.
  - Gas/brake, button released: move down toward 0 by RAMP_STEP, saturate.
  - Arithmetic uses 9-bit intermediates, then clamps.
- Conversion FSM, states IDLE and CONV:
  - IDLE + ch_we: latch ch_din, counter=CONV_TICKS-1, busy=1, go to CONV on the next clk.
  - CONV: counter decrements on each cen. When counter==0 and cen:
    - sample the selected source into dout;
    - busy=0; go to IDLE.
  - ch_we during CONV: relatch channel, reload counter (restart); dout unchanged.
  - ch_we on the same cycle as completion: restart wins; dout is not updated.
- rd has no side effects; dout is valid at any time and holds the old value while busy.
- Ramps keep updating during a conversion; the sample is taken at the completion instant.
- ctrl_type changes take effect immediately on the source mux; ramp state is kept.

Optional Feature:
- Macro JTOUTRUN_ADC_STATUS_EN adds inputs st_addr[1:0] and output st_dout[7:0].
- st_addr decoding: 0 = steer ramp, 1 = gas ramp, 2 = brake ramp, 3 = {busy, 2'b0, state, 1'b0, channel}.
- st_dout is registered on clk, reset 0.
- Without the macro: ports absent, no status logic.

Decomposition:
- Package jtoutrun_adc_pkg:
  - channel codes CH_STEER=0, CH_GAS=1, CH_BRAKE=2;
  - state enum IDLE/CONV;
  - centre constant 8'h80.
- One sub-module, jtoutrun_adc_ramp (instantiated three times): target/step/min/max in, saturating step toward target on frame tick.

Test Plan:
- Reset release, ctrl_type=1, joyana1[7:0]=8'h00, write ch0 -> busy=1 for 64 cen ticks, then dout=8'h80, busy=0.
- Analog joyana1[7:0]=8'h7F -> ch0 dout=8'hE0 (clamped); 8'h80 -> 8'h20.
- Digital, left held 20 frames -> steer ramp 80,78,...,20, then holds at 20; release -> climbs back to 80 in 12 frames, no overshoot.
- Digital gas held 40 frames -> ch1 conversion reads 8'hFF; release 2 frames -> 8'hEF.
- Write ch1, rewrite ch2 after 30 ticks -> busy stays high 64 ticks after the second write; dout = brake value, old dout held meanwhile.
- rst_n pulsed low mid-conversion -> busy=0, dout=0 immediately; next write converts normally.

Source files
------------

// File: rtl/jtoutrun_adc_pkg.sv
// Shared constants and types for the OutRun cabinet ADC emulation.
package jtoutrun_adc_pkg;

  localparam logic [2:0] CH_STEER = 3'd0;
  localparam logic [2:0] CH_GAS   = 3'd1;
  localparam logic [2:0] CH_BRAKE = 3'd2;

  localparam logic [7:0] CENTRE = 8'h80;

  typedef enum logic {IDLE, CONV} adc_state_e;

  function automatic logic [7:0] clamp8(input logic [7:0] v, input logic [7:0] lo,
                                        input logic [7:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/jtoutrun_adc_if.sv
// CPU-side I/O bus of the cabinet ADC: channel write, read strobe and result.
interface jtoutrun_adc_if;
  logic       ch_we;
  logic [2:0] ch_din;
  logic       rd;
  logic [7:0] dout;
  logic       busy;

  modport master (output ch_we, ch_din, rd, input dout, busy);
  modport slave  (input ch_we, ch_din, rd, output dout, busy);
endinterface

// File: rtl/jtoutrun_adc_ramp.sv
// Frame-rate ramp: steps toward a target by a fixed amount, never overshooting,
// and keeps the result inside [lo, hi].
module jtoutrun_adc_ramp #(
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [7:0] target,
  input  logic [7:0] step,
  input  logic [7:0] lo,
  input  logic [7:0] hi,
  output logic [7:0] value
);

  logic [8:0] up, dn;
  logic [7:0] moved, nxt;

  always_comb begin
    up    = {1'b0, value} + {1'b0, step};
    dn    = {1'b0, value} - {1'b0, step};
    moved = value;
    if (value < target) begin
      moved = (up > {1'b0, target}) ? target : up[7:0];
    end else if (value > target) begin
      // dn[8] is the borrow: stepping would go below zero
      moved = (dn[8] || dn[7:0] < target) ? target : dn[7:0];
    end
    nxt = moved;
    if (moved < lo) nxt = lo;
    if (moved > hi) nxt = hi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= INIT;
    end else if (tick) begin
      value <= nxt;
    end
  end

endmodule

// File: rtl/jtoutrun_adc.sv
// OutRun cabinet ADC (ADC0804-style): channel write starts a timed conversion.
// Optional status read port enabled by JTOUTRUN_ADC_STATUS_EN.
module jtoutrun_adc
  import jtoutrun_adc_pkg::*;
#(
  parameter int unsigned CONV_TICKS = 64,
  parameter logic [7:0]  RAMP_STEP  = 8'd8,
  parameter logic [7:0]  STEER_MIN  = 8'h20,
  parameter logic [7:0]  STEER_MAX  = 8'hE0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        vs,
  input  logic [2:0]  ctrl_type,
  input  logic [7:0]  joystick1,
  input  logic [15:0] joyana1,
  input  logic [15:0] joyana1b,
  jtoutrun_adc_if.slave bus
`ifdef JTOUTRUN_ADC_STATUS_EN
  ,
  input  logic [1:0]  st_addr,
  output logic [7:0]  st_dout
`endif
);

  localparam int unsigned CntW = (CONV_TICKS > 1) ? $clog2(CONV_TICKS) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(CONV_TICKS - 1);

  adc_state_e    state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]    chan_q;
  logic [7:0]    dout_q;
  logic          busy_q;
  logic          vs_q, tick_q;
  logic [7:0]    steer_ramp, gas_ramp, brake_ramp;
  logic [7:0]    steer_tgt, gas_tgt, brake_tgt;
  logic [7:0]    steer_ana, src;
  logic          analog, left, right;

  // Only the read strobe and unused cabinet bits land here; reads have no side effects.
  logic unused_bits;
  assign unused_bits = ^{bus.rd, joystick1[7:6], joystick1[3:2], joyana1[15:8]};

  assign analog = (ctrl_type != 3'd0);
  assign right  = ~joystick1[0];
  assign left   = ~joystick1[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      vs_q   <= vs;
      tick_q <= vs & ~vs_q;
    end
  end

  always_comb begin
    steer_tgt = CENTRE;
    if (left && !right) steer_tgt = STEER_MIN;
    if (right && !left) steer_tgt = STEER_MAX;
    gas_tgt   = ~joystick1[4] ? 8'hFF : 8'h00;
    brake_tgt = ~joystick1[5] ? 8'hFF : 8'h00;
  end

  jtoutrun_adc_ramp #(.INIT(CENTRE)) u_steer (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (tick_q),
    .target (steer_tgt),
    .step   (RAMP_STEP),
    .lo     (STEER_MIN),
    .hi     (STEER_MAX),
    .value  (steer_ramp)
  );

  jtoutrun_adc_ramp #(.INIT(8'h00)) u_gas (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (tick_q),
    .target (gas_tgt),
    .step   (RAMP_STEP),
    .lo     (8'h00),
    .hi     (8'hFF),
    .value  (gas_ramp)
  );

  jtoutrun_adc_ramp #(.INIT(8'h00)) u_brake (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (tick_q),
    .target (brake_tgt),
    .step   (RAMP_STEP),
    .lo     (8'h00),
    .hi     (8'hFF),
    .value  (brake_ramp)
  );

  assign steer_ana = clamp8(joyana1[7:0] ^ CENTRE, STEER_MIN, STEER_MAX);

  always_comb begin
    src = 8'h00;
    case (chan_q)
      CH_STEER: src = analog ? steer_ana     : steer_ramp;
      CH_GAS:   src = analog ? joyana1b[7:0] : gas_ramp;
      CH_BRAKE: src = analog ? joyana1b[15:8] : brake_ramp;
      default:  src = 8'h00;
    endcase
  end

  // A channel write always wins, including on the completion cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      chan_q  <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
    end else if (bus.ch_we) begin
      chan_q  <= bus.ch_din;
      cnt_q   <= CntLoad;
      busy_q  <= 1'b1;
      state_q <= CONV;
    end else begin
      case (state_q)
        IDLE: ;
        CONV: begin
          if (cen) begin
            if (cnt_q == '0) begin
              dout_q  <= src;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dout = dout_q;
  assign bus.busy = busy_q;

`ifdef JTOUTRUN_ADC_STATUS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_dout <= 8'h00;
    end else begin
      case (st_addr)
        2'd0:    st_dout <= steer_ramp;
        2'd1:    st_dout <= gas_ramp;
        2'd2:    st_dout <= brake_ramp;
        default: st_dout <= {busy_q, 2'b00, state_q, 1'b0, chan_q};
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_jtoutrun_adc.sv
// Directed and randomized bench for jtoutrun_adc against a frame-level model.
module tb_jtoutrun_adc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b0;
  logic        vs = 1'b0;
  logic [2:0]  ctrl_type = 3'd1;
  logic [7:0]  joystick1 = 8'hFF;
  logic [15:0] joyana1 = 16'h0000;
  logic [15:0] joyana1b = 16'h0000;
`ifdef JTOUTRUN_ADC_STATUS_EN
  logic [1:0]  st_addr = 2'd0;
  logic [7:0]  st_dout;
`endif

  jtoutrun_adc_if bus ();

  jtoutrun_adc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .vs        (vs),
    .ctrl_type (ctrl_type),
    .joystick1 (joystick1),
    .joyana1   (joyana1),
    .joyana1b  (joyana1b),
    .bus       (bus)
`ifdef JTOUTRUN_ADC_STATUS_EN
    ,
    .st_addr   (st_addr),
    .st_dout   (st_dout)
`endif
  );

  always #5 clk = ~clk;
  always @(negedge clk) cen = ~cen;

  int total = 0;
  int bad = 0;
  // Model of the digital ramps, advanced once per frame
  int m_steer = 128;
  int m_gas = 0;
  int m_brake = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int toward(input int cur, input int tgt);
    if (cur < tgt) return (cur + 8 > tgt) ? tgt : cur + 8;
    if (cur > tgt) return (cur - 8 < tgt) ? tgt : cur - 8;
    return cur;
  endfunction

  function automatic int expected(input int ch);
    logic signed [7:0] s;
    int v;
    if (ctrl_type != 3'd0) begin
      s = joyana1[7:0];
      v = int'(s) + 128;
      if (ch == 0) return (v < 32) ? 32 : (v > 224) ? 224 : v;
      if (ch == 1) return int'(joyana1b[7:0]);
      if (ch == 2) return int'(joyana1b[15:8]);
      return 0;
    end
    if (ch == 0) return m_steer;
    if (ch == 1) return m_gas;
    if (ch == 2) return m_brake;
    return 0;
  endfunction

  task automatic frame();
    bit l, r;
    int tgt;
    l = !joystick1[1];
    r = !joystick1[0];
    tgt = (l && !r) ? 32 : (r && !l) ? 224 : 128;
    m_steer = toward(m_steer, tgt);
    m_gas   = toward(m_gas, joystick1[4] ? 0 : 255);
    m_brake = toward(m_brake, joystick1[5] ? 0 : 255);
    @(negedge clk) vs = 1'b1;
    repeat (4) @(negedge clk);
    vs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic write_ch(input logic [2:0] ch);
    @(negedge clk);
    bus.ch_din = ch;
    bus.ch_we  = 1'b1;
    @(posedge clk);
    #1 bus.ch_we = 1'b0;
    check("busy_after_write", bus.busy, 1);
  endtask

  task automatic wait_done(output int ticks);
    ticks = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      if (cen) ticks++;
      #1;
      if (!bus.busy) break;
    end
  endtask

  task automatic conv_check(input string tag, input int ch);
    int ticks;
    int exp;
    write_ch(3'(ch));
    wait_done(ticks);
    exp = expected(ch);
    check({tag, "_ticks"}, ticks, 64);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_dout"}, bus.dout, exp);
  endtask

  initial begin
    int ticks;
    bus.ch_we  = 1'b0;
    bus.ch_din = 3'd0;
    bus.rd     = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_dout", bus.dout, 0);
    check("reset_busy", bus.busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Analog steering, centre and clamps
    joyana1 = 16'h0000;
    conv_check("ana_centre", 0);
    joyana1 = 16'h007F;
    conv_check("ana_max", 0);
    joyana1 = 16'h0080;
    conv_check("ana_min", 0);

    for (int i = 0; i < 8; i++) begin
      joyana1  = 16'($urandom);
      joyana1b = 16'($urandom);
      conv_check("ana_rand", int'($urandom_range(0, 7)));
    end

    // Digital: left held, then released
    ctrl_type = 3'd0;
    joystick1 = 8'hFD;
    for (int i = 0; i < 20; i++) begin
      frame();
      conv_check("steer_left", 0);
    end
    joystick1 = 8'hFF;
    for (int i = 0; i < 12; i++) begin
      frame();
      conv_check("steer_back", 0);
    end
    frame();
    conv_check("steer_hold", 0);

    // Gas saturation then release
    joystick1 = 8'hEF;
    for (int i = 0; i < 40; i++) frame();
    conv_check("gas_full", 1);
    check("gas_full_const", bus.dout, 8'hFF);
    joystick1 = 8'hFF;
    frame();
    frame();
    conv_check("gas_release", 1);
    check("gas_release_const", bus.dout, 8'hEF);

    for (int i = 0; i < 8; i++) begin
      joystick1 = 8'($urandom);
      frame();
      conv_check("dig_rand", int'($urandom_range(0, 7)));
    end

    // Restart: rewriting mid-conversion restarts the full count
    ctrl_type = 3'd1;
    joyana1   = 16'h0010;
    conv_check("pre_restart", 0);
    joyana1b  = 16'h5A33;
    write_ch(3'd1);
    ticks = 0;
    for (int i = 0; i < 200 && ticks < 30; i++) begin
      @(posedge clk);
      if (cen) ticks++;
    end
    #1;
    check("restart_busy_mid", bus.busy, 1);
    check("restart_old_dout", bus.dout, 8'h90);
    write_ch(3'd2);
    wait_done(ticks);
    check("restart_ticks", ticks, 64);
    check("restart_dout", bus.dout, 8'h5A);

    // Asynchronous reset mid-conversion
    write_ch(3'd1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", bus.busy, 0);
    check("midreset_dout", bus.dout, 0);
    m_steer = 128;
    m_gas   = 0;
    m_brake = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    joyana1 = 16'h0040;
    conv_check("post_reset", 0);
    ctrl_type = 3'd0;
    conv_check("post_reset_ramp", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
